// File: rtl/chan_scan_seq.sv
// Multi-channel scan sequencer: settles then dwells on each enabled channel of a 4:1 selector.
// Optional macro SCAN_CNT_EN adds the Scan_cnt completed-pass counter output.
module chan_scan_seq #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Start,
  input  logic       Stop,
  input  logic [3:0] Mask,
  input  logic [7:0] Dwell,
  input  logic       Cont,
  output logic [1:0] S,
  output logic       Sample,
  output logic       Busy,
  output logic       Done,
  output logic       Err
`ifdef SCAN_CNT_EN
  ,
  output logic [15:0] Scan_cnt
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       mask_q, mask_d;
  logic [7:0]       dwell_q, dwell_d;
  logic             cont_q, cont_d;
  logic [1:0]       s_q, s_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [1:0]       nxt_ch;
  logic             wrap;
  logic             start_ok;
  logic             dwell_last;

  function automatic logic [1:0] low_bit(input logic [3:0] m);
    low_bit = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) low_bit = 2'(i);
    end
  endfunction

  assign start_ok   = (state_q == IDLE) && Start && !Stop;
  assign dwell_last = (state_q == DWELL) && (cnt_q == dwell_q);

  // Next higher enabled channel; wrap when none lies above the current one
  always_comb begin
    nxt_ch = low_bit(mask_q);
    wrap   = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if ((i > int'(s_q)) && mask_q[i]) begin
        nxt_ch = 2'(i);
        wrap   = 1'b0;
      end
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    cont_d  = cont_q;
    s_d     = s_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          mask_d  = Mask;
          dwell_d = Dwell;
          cont_d  = Cont;
          if (Mask == 4'd0) begin
            err_d = 1'b1;
          end else begin
            s_d     = low_bit(Mask);
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = DWELL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DWELL: begin
        if (dwell_last) begin
          cnt_d = '0;
          if (wrap && !cont_q) begin
            state_d = DONE;
          end else begin
            s_d     = nxt_ch;
            state_d = SETTLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything; the selector keeps its last channel
    if (Stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      s_d     = s_q;
      err_d   = 1'b0;
    end

    sample_d = (state_d == DWELL);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mask_q   <= '0;
      dwell_q  <= '0;
      cont_q   <= 1'b0;
      s_q      <= 2'd0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      dwell_q  <= dwell_d;
      cont_q   <= cont_d;
      s_q      <= s_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign S      = s_q;
  assign Sample = sample_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Err    = err_q;

`ifdef SCAN_CNT_EN
  // Completed-pass counter: bumps on every wrap, saturating
  logic [15:0] scnt_q, scnt_d;
  logic        pass_done;

  assign pass_done = dwell_last && wrap;

  always_comb begin
    scnt_d = scnt_q;
    if (start_ok) begin
      scnt_d = '0;
    end else if (pass_done && (scnt_q != 16'hFFFF)) begin
      scnt_d = scnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scnt_q <= '0;
    end else begin
      scnt_q <= scnt_d;
    end
  end

  assign Scan_cnt = scnt_q;
`endif

endmodule

// File: tb/tb_chan_scan_seq.sv
// Self-checking bench for chan_scan_seq: directed and randomized scans against a trace-list model.
module tb_chan_scan_seq;

  localparam int unsigned SETTLE = 2;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Start;
  logic       Stop;
  logic [3:0] Mask;
  logic [7:0] Dwell;
  logic       Cont;
  logic [1:0] S;
  logic       Sample;
  logic       Busy;
  logic       Done;
  logic       Err;
`ifdef SCAN_CNT_EN
  logic [15:0] Scan_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Expected per-cycle trace {S, Sample, Busy, Done, Err} and pass count
  logic [5:0] eq[$];
  int         cq[$];
  logic [1:0] cur_s;
  int         cur_cnt;
  int         busy_seen;

  always #5 Clk = ~Clk;

  chan_scan_seq #(.SETTLE_CYC(SETTLE)) dut (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .Start  (Start),
    .Stop   (Stop),
    .Mask   (Mask),
    .Dwell  (Dwell),
    .Cont   (Cont),
    .S      (S),
    .Sample (Sample),
    .Busy   (Busy),
    .Done   (Done),
    .Err    (Err)
`ifdef SCAN_CNT_EN
    ,
    .Scan_cnt (Scan_cnt)
`endif
  );

  function automatic logic [5:0] obs();
    return {S, Sample, Busy, Done, Err};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input int exp);
`ifdef SCAN_CNT_EN
    checks++;
    assert (Scan_cnt === 16'(exp)) else begin
      errors++;
      $error("FAIL %s_cnt observed %0d expected %0d", tag, Scan_cnt, exp);
    end
`else
    if (tag.len() < 0 || exp < -1) $display("unreachable");
`endif
  endtask

  // Trace model: list enabled channels, expand each into settle and dwell cycles per pass
  function automatic void build(input logic [3:0] m, input int dw, input bit c, input int len);
    int chans[$];
    int passes;
    logic [1:0] last;
    passes = 0;
    eq.delete();
    cq.delete();
    for (int i = 0; i < 4; i++) if (m[i]) chans.push_back(i);
    if (chans.size() == 0) begin
      eq.push_back({cur_s, 4'b0001}); cq.push_back(0);
      eq.push_back({cur_s, 4'b0000}); cq.push_back(0);
      return;
    end
    do begin
      foreach (chans[k]) begin
        for (int j = 0; j < int'(SETTLE); j++) begin
          eq.push_back({2'(chans[k]), 4'b0100}); cq.push_back(passes);
        end
        for (int j = 0; j <= dw; j++) begin
          eq.push_back({2'(chans[k]), 4'b1100}); cq.push_back(passes);
        end
      end
      passes++;
    end while (c && eq.size() < len);
    if (!c) begin
      last = 2'(chans[chans.size()-1]);
      eq.push_back({last, 4'b0110}); cq.push_back(passes);
      eq.push_back({last, 4'b0000}); cq.push_back(passes);
    end
  endfunction

  // mode 0: run to completion, 1: Stop after stop_at cycles, 2: async reset after stop_at cycles
  task automatic scan(input string tag, input logic [3:0] m, input logic [7:0] dw, input bit c,
                      input int stop_at, input int mode, input bit noise);
    build(m, int'(dw), c, stop_at + 4);
    busy_seen = 0;
    Start = 1'b1; Mask = m; Dwell = dw; Cont = c;
    tick();
    Start = 1'b0;
    for (int i = 0; i < eq.size(); i++) begin
      check(tag, obs(), eq[i]);
      check_cnt(tag, cq[i]);
      busy_seen += int'(Busy);
      cur_s   = eq[i][5:4];
      cur_cnt = cq[i];
      if (mode != 0 && i + 1 == stop_at) begin
        Start = 1'b0;
        if (mode == 1) begin
          Stop = 1'b1;
          tick();
          Stop = 1'b0;
          check({tag, "_stop"}, obs(), {cur_s, 4'b0000});
          check_cnt({tag, "_stop"}, cur_cnt);
        end else begin
          #2 Rst_n = 1'b0;
          #1;
          cur_s = 2'd0; cur_cnt = 0;
          check({tag, "_rst"}, obs(), 6'b0);
          check_cnt({tag, "_rst"}, 0);
          @(posedge Clk);
          #1 Rst_n = 1'b1;
        end
        return;
      end
      // Start and config churn while busy must be ignored
      if (noise && eq[i][2]) begin
        Start = 1'($urandom_range(0, 1));
        Mask  = 4'($urandom);
        Dwell = 8'($urandom);
        Cont  = 1'($urandom);
      end else begin
        Start = 1'b0;
      end
      tick();
    end
    Start = 1'b0;
  endtask

  initial begin
    logic [3:0] m;
    logic [7:0] dw;
    bit         c;
    Rst_n = 1'b0; Start = 1'b0; Stop = 1'b0; Mask = 4'd0; Dwell = 8'd0; Cont = 1'b0;
    cur_s = 2'd0; cur_cnt = 0;
    #3;
    check("reset", obs(), 6'b0);
    check_cnt("reset", 0);
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    tick();
    check("post_reset_idle", obs(), 6'b0);

    // Two-channel one-shot: 13 busy cycles
    scan("mask1010", 4'b1010, 8'd3, 1'b0, 0, 0, 1'b0);
    checks++;
    assert (busy_seen === 13) else begin
      errors++;
      $error("FAIL busy_len observed %0d expected %0d", busy_seen, 13);
    end

    // Empty mask -> Err pulse only
    scan("mask0000", 4'b0000, 8'd5, 1'b0, 0, 0, 1'b0);

    // Continuous 0,3,0,3 with Stop during a DWELL cycle (index 8)
    scan("cont1001", 4'b1001, 8'd0, 1'b1, 9, 1, 1'b0);

    // Single channel, maximum dwell
    scan("dwell255", 4'b0100, 8'd255, 1'b0, 0, 0, 1'b0);
    checks++;
    assert (busy_seen === 256 + int'(SETTLE) + 1) else begin
      errors++;
      $error("FAIL dwell255_busy observed %0d expected %0d", busy_seen, 256 + int'(SETTLE) + 1);
    end

    // Start and Stop together in IDLE: nothing happens
    Start = 1'b1; Stop = 1'b1; Mask = 4'b0110; Dwell = 8'd2; Cont = 1'b1;
    tick();
    Start = 1'b0; Stop = 1'b0;
    check("start_stop", obs(), {cur_s, 4'b0000});
    check_cnt("start_stop", cur_cnt);
    tick();
    check("start_stop_hold", obs(), {cur_s, 4'b0000});

    // Reset mid-DWELL, then a Start right after release
    scan("rst_dwell", 4'b1010, 8'd3, 1'b1, 4, 2, 1'b0);
    scan("after_rst", 4'b0011, 8'd1, 1'b0, 0, 0, 1'b0);

    // Full mask continuous: pass count per four channels, then cleared by new Start
    scan("mask1111", 4'b1111, 8'd1, 1'b1, 40, 1, 1'b1);
    scan("mask1111_b", 4'b1111, 8'd0, 1'b0, 0, 0, 1'b1);

    // Randomized scans with busy-time noise
    for (int n = 0; n < 12; n++) begin
      m  = 4'($urandom);
      dw = 8'($urandom_range(0, 6));
      c  = 1'($urandom);
      if (c) scan("rand_cont", m, dw, 1'b1, $urandom_range(1, 40), 1, 1'b1);
      else   scan("rand_shot", m, dw, 1'b0, 0, 0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chan_scan_seq.md
CHAN_SCAN_SEQ -- requirements
Module: chan_scan_seq

Interface
REQ-001 SETTLE_CYC, default 2, cycles S is held stable before sampling begins (legal 1..15).
REQ-002 Clk  input  1  clock; all logic on rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Start  input  1  single-cycle request to begin a scan; honoured only in IDLE.
REQ-005 Stop  input  1  abort request; honoured in any state.
REQ-006 Mask  input  4  channel enable, bit n enables channel n; latched on accepted Start.
REQ-007 Dwell  input  8  sample cycles per channel minus one; latched on accepted Start.
REQ-008 Cont  input  1  1 = continuous scanning, 0 = one-shot; latched on accepted Start.
REQ-009 S  output  2  channel select driven to the downstream 4:1 selector.
REQ-010 Sample  output  1  high during every DWELL cycle; downstream output is valid to capture.
REQ-011 Busy  output  1  high in every state except IDLE.
REQ-012 Done  output  1  one-cycle pulse when a one-shot scan completes.
REQ-013 Err  output  1  one-cycle pulse when Start is accepted with Mask == 0.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, DWELL, DONE; S, Sample, Busy, Done, Err are registered outputs.
REQ-015 IDLE: Start=1, Stop=0, latched Mask != 0 -> S = lowest set Mask bit, enter SETTLE next cycle.
REQ-016 IDLE: Start=1 with Mask == 0 -> Err=1 for one cycle, remain IDLE, S unchanged.
REQ-017 SETTLE SHALL last exactly SETTLE_CYC cycles with Sample=0, then enter DWELL.
REQ-018 DWELL SHALL last exactly Dwell+1 cycles (Dwell=0 -> 1 cycle, Dwell=255 -> 256 cycles) with Sample=1.
REQ-019 On the last DWELL cycle the next channel SHALL be the next higher set Mask bit, wrapping 3 -> 0 to the lowest set bit.
REQ-020 Wrap (next channel <= current, including a single-bit mask) with Cont=0 -> enter DONE; Done=1 one cycle; then IDLE.
REQ-021 Non-wrap, or wrap with Cont=1 -> S updates to the next channel and SETTLE restarts.
REQ-022 S SHALL change only on entry to SETTLE; S is never modified during SETTLE or DWELL.
REQ-023 Stop=1 in any state SHALL force IDLE on the next edge: Sample=0, Busy=0, S holds last value, Done not pulsed.
REQ-024 Start and Stop in the same IDLE cycle: Stop wins, Start ignored, no Err.
REQ-025 Start while Busy=1 SHALL be ignored; Mask/Dwell/Cont changes while Busy have no effect.

Reset
REQ-026 Rst_n low SHALL immediately force IDLE, S=2'b00, Sample=0, Busy=0, Done=0, Err=0, counters and latched configuration cleared.
REQ-027 Reset asserted mid-scan SHALL abort the scan with no Done pulse; first Start is accepted on the first edge after release.

Configuration
REQ-028 Macro SCAN_CNT_EN SHALL add output Scan_cnt [15:0]: count of completed full passes (each wrap), cleared on accepted Start and on reset, saturating at 16'hFFFF.
REQ-029 Without SCAN_CNT_EN the Scan_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Mask=4'b1010, Dwell=3, Cont=0, SETTLE_CYC=2, Start -> S=1: 2 SETTLE + 4 Sample cycles; S=3: 2 + 4; Done pulse; IDLE; Busy high 13 cycles.
REQ-031 Mask=4'b0000, Start -> Err one cycle, Busy stays 0, S stays 0.
REQ-032 Mask=4'b1001, Dwell=0, Cont=1 -> S sequence 0,3,0,3..., one Sample cycle each; Stop mid-DWELL -> next cycle Busy=0, Sample=0, no Done.
REQ-033 Mask=4'b0100, Cont=0, Dwell=255 -> single channel S=2, exactly 256 Sample cycles, Done.
REQ-034 Start and Stop same cycle in IDLE -> no activity; Rst_n pulsed low during DWELL -> outputs at reset values asynchronously.
REQ-035 SCAN_CNT_EN defined, Mask=4'b1111, Cont=1 -> Scan_cnt increments by 1 per 4 channels; new Start clears to 0.
